// File: rtl/mem_dump_streamer.sv
// Snapshots a flat WORDS x WIDTH memory image on start and streams it MSB-byte-first
// over valid/ready. Optional trailing mod-256 checksum byte when MEM_DUMP_CHECKSUM_EN is defined.
module mem_dump_streamer #(
  parameter int WORDS = 19,
  parameter int WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORDS*WIDTH-1:0] mem_bus,
  input  logic                   start,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             dbg_state_o
);

  localparam int BYTES = WIDTH / 8;
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WW-1:0] LAST_WORD = WW'(WORDS - 1);
  localparam logic [1:0]    LAST_BYTE = 2'(BYTES - 1);

  // Handshake: a byte moves on any rising edge where tx_valid & tx_ready; while
  // tx_valid is high and tx_ready low, tx_data and tx_valid are held unchanged.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef MEM_DUMP_CHECKSUM_EN
    CSUM = 2'd2,
`endif
    SEND = 2'd1
  } state_t;

  state_t            state_q, state_d;
  logic [WW-1:0]     word_q, word_d;
  logic [1:0]        byte_q, byte_d;
  logic              done_q, done_d;
  logic              snap_load;
  logic [WIDTH-1:0]  snap_q [WORDS];
  logic [WIDTH-1:0]  cur_word;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign tx_valid    = (state_q != IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign dbg_state_o = state_q;

  // Output byte is selected straight from the frozen snapshot, so it is stable under stall.
  always_comb begin
    cur_word = snap_q[word_q];
    tx_data  = 8'h00;
    if (state_q == SEND) begin
      for (int b = 0; b < BYTES; b++) begin
        if (byte_q == 2'(b)) tx_data = cur_word[8*(BYTES-1-b) +: 8];
      end
    end
`ifdef MEM_DUMP_CHECKSUM_EN
    else if (state_q == CSUM) begin
      tx_data = csum_q;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    byte_d    = byte_q;
    done_d    = 1'b0;
    snap_load = 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SEND;
          word_d    = '0;
          byte_d    = '0;
          snap_load = 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
          csum_d    = 8'h00;
`endif
        end
      end
      SEND: begin
        if (tx_ready) begin
`ifdef MEM_DUMP_CHECKSUM_EN
          csum_d = csum_q + tx_data;
`endif
          if (byte_q == LAST_BYTE) begin
            byte_d = '0;
            if (word_q == LAST_WORD) begin
              word_d = '0;
`ifdef MEM_DUMP_CHECKSUM_EN
              state_d = CSUM;
`else
              state_d = IDLE;
              done_d  = 1'b1;
`endif
            end else begin
              word_d = word_q + 1'b1;
            end
          end else begin
            byte_d = byte_q + 2'd1;
          end
        end
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      CSUM: begin
        if (tx_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
`ifdef MEM_DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Snapshot is pure datapath; it is only observed after a fresh load.
  always_ff @(posedge clk) begin
    if (snap_load) begin
      for (int k = 0; k < WORDS; k++) snap_q[k] <= mem_bus[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Bench for mem_dump_streamer: vector table of memory images / ready rates plus
// hand sequences for snapshot isolation, restart in done cycle, start-while-busy and reset mid-stream.
module tb_mem_dump_streamer;
  localparam int WORDS = 19;
  localparam int WIDTH = 24;
`ifdef MEM_DUMP_CHECKSUM_EN
  localparam int TOTAL = WORDS*3 + 1;
`else
  localparam int TOTAL = WORDS*3;
`endif

  logic                   clk = 1'b0;
  logic                   rst, start, tx_ready;
  logic [WORDS*WIDTH-1:0] mem_bus;
  logic [7:0]             tx_data;
  logic                   tx_valid, busy, done;
  logic [1:0]             dbg_state;

  int         vec_cnt  = 0;
  int         fail_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [23:0] m0;
    logic [23:0] m1;
    logic [23:0] fill;
    int          ready_pct;
    logic [7:0]  exp_first;
    int          exp_bytes;
  } vec_t;
  vec_t vecs[4];

  mem_dump_streamer dut (
    .clk(clk), .rst(rst), .mem_bus(mem_bus), .start(start),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_mem(input logic [23:0] m0, input logic [23:0] m1, input logic [23:0] fill);
    for (int k = 0; k < WORDS; k++) mem_bus[k*WIDTH +: WIDTH] = fill;
    mem_bus[0 +: WIDTH]     = m0;
    mem_bus[WIDTH +: WIDTH] = m1;
  endtask

  // Model of the expected byte stream built from the image being driven.
  task automatic push_expected();
    logic [7:0]  s = 8'h00;
    logic [23:0] w;
    exp_q.delete();
    for (int k = 0; k < WORDS; k++) begin
      w = mem_bus[k*WIDTH +: WIDTH];
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
      s = s + w[23:16] + w[15:8] + w[7:0];
    end
`ifdef MEM_DUMP_CHECKSUM_EN
    exp_q.push_back(s);
`endif
  endtask

  // Called at a negedge; returns at the negedge one cycle after start.
  task automatic start_dump();
    push_expected();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_valid", {31'd0, tx_valid}, 32'd1);
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_done", {31'd0, done}, 32'd0);
  endtask

  // Consumes the stream; returns at the done negedge, or one cycle after a mid-stream reset.
  task automatic run_dump(input int pct, input int start_at, input int rst_at,
                          output int nbytes, output bit saw_done);
    bit         stall  = 1'b0;
    bit         pulsed = 1'b0;
    logic [7:0] prev   = 8'h00;
    nbytes   = 0;
    saw_done = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (done) begin
        saw_done = 1'b1;
        start    = 1'b0;
        tx_ready = 1'b0;
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_valid", {31'd0, tx_valid}, 32'd0);
        return;
      end
      if (rst_at >= 0 && nbytes == rst_at) begin
        tx_ready = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_data", {24'd0, tx_data}, 32'd0);
        @(negedge clk);
        check("rst_no_done", {31'd0, done}, 32'd0);
        exp_q.delete();
        return;
      end
      check("stream_valid", {31'd0, tx_valid}, 32'd1);
      if (stall) check("hold_data", {24'd0, tx_data}, {24'd0, prev});
      start = (start_at >= 0 && nbytes == start_at && !pulsed);
      if (start) pulsed = 1'b1;
      tx_ready = ($urandom_range(99) < pct);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) check("extra_byte", nbytes, TOTAL - 1);
        else check("byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        nbytes++;
      end
      stall = tx_valid && !tx_ready;
      prev  = tx_data;
      @(negedge clk);
    end
    start    = 1'b0;
    tx_ready = 1'b0;
    check("timeout_done", {31'd0, saw_done}, 32'd1);
  endtask

  task automatic finish_checks(input string tag, input int n, input bit sd);
    check({tag, "_done_seen"}, {31'd0, sd}, 32'd1);
    check({tag, "_count"}, n, TOTAL);
    check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int n;
    bit sd;
    vecs[0] = '{24'h123456, 24'hABCDEF, 24'h000000, 100, 8'h12, TOTAL};
    vecs[1] = '{24'h123456, 24'hABCDEF, 24'h000000, 50,  8'h12, TOTAL};
    vecs[2] = '{24'hFFFFFF, 24'h000001, 24'hA5C3E7, 30,  8'hFF, TOTAL};
    vecs[3] = '{24'h80FF01, 24'h7E0081, 24'h800001, 75,  8'h80, TOTAL};

    rst = 1'b1; start = 1'b0; tx_ready = 1'b0; mem_bus = '0;
    repeat (2) @(negedge clk);
    check("reset_valid", {31'd0, tx_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_data", {24'd0, tx_data}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      set_mem(vecs[i].m0, vecs[i].m1, vecs[i].fill);
      start_dump();
      check("first_byte", {24'd0, tx_data}, {24'd0, vecs[i].exp_first});
      run_dump(vecs[i].ready_pct, -1, -1, n, sd);
      check("vec_count", n, vecs[i].exp_bytes);
      finish_checks("vec", n, sd);
      @(negedge clk);
      check("done_width", {31'd0, done}, 32'd0);
      check("idle_after", {31'd0, tx_valid}, 32'd0);
    end

    // start asserted in the done cycle launches the next dump immediately
    set_mem(24'h123456, 24'hABCDEF, 24'h000000);
    start_dump();
    run_dump(100, -1, -1, n, sd);
    finish_checks("pre_restart", n, sd);
    start_dump();
    check("restart_first", {24'd0, tx_data}, 32'h12);
    run_dump(60, -1, -1, n, sd);
    finish_checks("restart", n, sd);
    @(negedge clk);

    // snapshot isolation: image changes after the start edge
    start_dump();
    set_mem(24'hFFFFFF, 24'h5A5A5A, 24'h3C3C3C);
    run_dump(100, -1, -1, n, sd);
    finish_checks("snapshot", n, sd);
    @(negedge clk);

    // start re-pulsed mid-stream is ignored
    set_mem(24'h123456, 24'hABCDEF, 24'h000000);
    start_dump();
    run_dump(100, 5, -1, n, sd);
    finish_checks("repulse", n, sd);
    @(negedge clk);
    check("repulse_no_requeue", {31'd0, tx_valid}, 32'd0);

    // reset after 10 bytes, then a clean restart
    start_dump();
    run_dump(100, -1, 10, n, sd);
    check("rst_bytes", n, 32'd10);
    check("rst_saw_no_done", {31'd0, sd}, 32'd0);
    start_dump();
    check("after_rst_first", {24'd0, tx_data}, 32'h12);
    run_dump(50, -1, -1, n, sd);
    finish_checks("after_rst", n, sd);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end
endmodule
